// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - byte-addressed instruction memory with valid/ready fetch,
// configurable latency/endianness, misalignment flag and a byte load port.
module imem_ctrl #(
  parameter int ADDR_W     = 9,
  parameter int WORD_BYTES = 4,
  parameter int LATENCY    = 0,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*WORD_BYTES-1:0] rsp_data,
  output logic                    rsp_err,
  input  logic                    ld_en,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [7:0]              ld_data
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(WORD_BYTES - 1);

  logic [7:0] Mem [2**ADDR_W];

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic [ADDR_W-1:0]       r_addr;
  logic                    r_req_ready;
  logic                    r_rsp_valid;
  logic                    r_rsp_err;
  logic [8*WORD_BYTES-1:0] r_rsp_data;

  logic [8*WORD_BYTES-1:0] w_word;
  logic                    w_misaligned;

  // Load port has no reset so preloads survive (and can happen during) reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      Mem[ld_addr] <= ld_data;
    end
  end

  always_comb begin
    w_word = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (BIG_ENDIAN != 0) begin
        w_word[8*(WORD_BYTES-1-i) +: 8] = Mem[r_addr + ADDR_W'(i)];
      end else begin
        w_word[8*i +: 8] = Mem[r_addr + ADDR_W'(i)];
      end
    end
  end

  assign w_misaligned = |(r_addr & OFF_MASK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr      <= req_addr;
            r_cnt       <= 4'(LATENCY);
            r_req_ready <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // Memory is sampled before this edge's load-port write lands.
            r_rsp_err   <= w_misaligned;
            r_rsp_data  <= w_misaligned ? '0 : w_word;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_imem_ctrl.sv
// tb/tb_imem_ctrl.sv - scoreboard bench for imem_ctrl across three
// latency/endianness configurations sharing one clock.
module tb_imem_ctrl;

  logic        clk;
  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic [8:0]  req_addr  [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_data  [3];
  logic        rsp_err   [3];
  logic        ld_en     [3];
  logic [8:0]  ld_addr   [3];
  logic [7:0]  ld_data   [3];

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q [$];

  // d0: LATENCY 0 big-endian, d1: LATENCY 3 little-endian, d2: LATENCY 2 big-endian
  imem_ctrl #(.ADDR_W(9), .WORD_BYTES(4), .LATENCY(0), .BIG_ENDIAN(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]), .ld_en(ld_en[0]),
    .ld_addr(ld_addr[0]), .ld_data(ld_data[0]));

  imem_ctrl #(.ADDR_W(9), .WORD_BYTES(4), .LATENCY(3), .BIG_ENDIAN(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]), .ld_en(ld_en[1]),
    .ld_addr(ld_addr[1]), .ld_data(ld_data[1]));

  imem_ctrl #(.ADDR_W(9), .WORD_BYTES(4), .LATENCY(2), .BIG_ENDIAN(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_data(rsp_data[2]), .rsp_err(rsp_err[2]), .ld_en(ld_en[2]),
    .ld_addr(ld_addr[2]), .ld_data(ld_data[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Starts at a falling edge with the DUT idle; returns at a falling edge with it idle again.
  task automatic fetch(input int d, input logic [8:0] a, output logic [31:0] data,
                       output logic err, output int lat, output logic rdy_low);
    req_addr[d]  = a;
    req_valid[d] = 1'b1;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 0;
    rdy_low = 1'b1;
    while (!rsp_valid[d] && lat < 64) begin
      if (req_ready[d]) rdy_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    data = rsp_data[d];
    err  = rsp_err[d];
    if (req_ready[d]) rdy_low = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_valid(input int d, output int lat);
    lat = 0;
    while (!rsp_valid[d] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_err[d] !== 1'b0 ||
          rsp_data[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d: ready=%b valid=%b err=%b data=%h, want 1 0 0 00000000",
                 d, req_ready[d], rsp_valid[d], rsp_err[d], rsp_data[d]);
      end
    end
  endtask

  task automatic test_aligned_be;
    logic [31:0] data; logic err; int lat; logic rl; logic [32:0] e;
    logic [8:0] addrs [2];
    addrs[0] = 9'd0; addrs[1] = 9'd4;
    exp_q.push_back({1'b0, 32'h00112233});
    exp_q.push_back({1'b0, 32'h44556677});
    for (int k = 0; k < 2; k++) begin
      fetch(0, addrs[k], data, err, lat, rl);
      e = exp_q.pop_front();
      checks++;
      if ({err, data} !== e || lat != 1) begin
        errors++;
        $display("FAIL aligned_be addr=%0d: err=%b data=%h lat=%0d, want err=%b data=%h lat=1",
                 addrs[k], err, data, lat, e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_latency_le;
    logic [31:0] data; logic err; int lat; logic rl; logic [32:0] e;
    exp_q.push_back({1'b0, 32'h77665544});
    fetch(1, 9'd4, data, err, lat, rl);
    e = exp_q.pop_front();
    checks++;
    if ({err, data} !== e || lat != 4) begin
      errors++;
      $display("FAIL latency_le: err=%b data=%h lat=%0d, want err=0 data=%h lat=4",
               err, data, lat, e[31:0]);
    end
    checks++;
    if (rl !== 1'b1) begin
      errors++;
      $display("FAIL latency_ready: req_ready seen 1 while busy, want 0 throughout");
    end
  endtask

  task automatic test_misaligned;
    logic [31:0] data; logic err; int lat; logic rl; logic [32:0] e;
    logic [8:0] addrs [2];
    addrs[0] = 9'h006; addrs[1] = 9'h000;
    exp_q.push_back({1'b1, 32'h0});
    exp_q.push_back({1'b0, 32'h00112233});
    for (int k = 0; k < 2; k++) begin
      fetch(0, addrs[k], data, err, lat, rl);
      e = exp_q.pop_front();
      checks++;
      if ({err, data} !== e || lat != 1) begin
        errors++;
        $display("FAIL misaligned addr=%h: err=%b data=%h lat=%0d, want err=%b data=%h lat=1",
                 addrs[k], err, data, lat, e[32], e[31:0]);
      end
    end
    exp_q.push_back({1'b1, 32'h0});
    fetch(1, 9'h002, data, err, lat, rl);
    e = exp_q.pop_front();
    checks++;
    if ({err, data} !== e || lat != 4) begin
      errors++;
      $display("FAIL misaligned_lat: err=%b data=%h lat=%0d, want err=1 data=0 lat=4",
               err, data, lat);
    end
  endtask

  task automatic test_backpressure;
    int lat; logic [32:0] e; int bad;
    req_addr[0]  = 9'd0;
    req_valid[0] = 1'b1;
    rsp_ready[0] = 1'b0;
    exp_q.push_back({1'b0, 32'h00112233});
    @(negedge clk);
    req_addr[0] = 9'd4;
    wait_valid(0, lat);
    e = exp_q.pop_front();
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid[0] !== 1'b1 || {rsp_err[0], rsp_data[0]} !== e || req_ready[0] !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0 || lat != 1) begin
      errors++;
      $display("FAIL backpressure_hold: %0d bad cycles, lat=%0d, data=%h ready=%b, want data=%h ready=0 lat=1",
               bad, lat, rsp_data[0], req_ready[0], e[31:0]);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: ready=%b valid=%b, want 1 0", req_ready[0], rsp_valid[0]);
    end
    exp_q.push_back({1'b0, 32'h44556677});
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_valid(0, lat);
    e = exp_q.pop_front();
    checks++;
    if ({rsp_err[0], rsp_data[0]} !== e || lat != 1) begin
      errors++;
      $display("FAIL backpressure_second: data=%h err=%b lat=%0d, want data=%h err=0 lat=1",
               rsp_data[0], rsp_err[0], lat, e[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_load_hazard;
    int lat; logic [32:0] e; logic [31:0] data; logic err; logic rl;
    req_addr[2] = 9'd0; req_valid[2] = 1'b1; rsp_ready[2] = 1'b1;
    exp_q.push_back({1'b0, 32'h00AA2233});
    @(negedge clk);
    req_valid[2] = 1'b0;
    ld_en[2] = 1'b1; ld_addr[2] = 9'd1; ld_data[2] = 8'hAA;
    @(negedge clk);
    ld_en[2] = 1'b0;
    wait_valid(2, lat);
    e = exp_q.pop_front();
    checks++;
    if ({rsp_err[2], rsp_data[2]} !== e || lat != 2) begin
      errors++;
      $display("FAIL load_early: data=%h lat=%0d, want data=%h lat=2", rsp_data[2], lat, e[31:0]);
    end
    @(negedge clk);
    ld_en[2] = 1'b1; ld_data[2] = 8'h11;
    @(negedge clk);
    ld_en[2] = 1'b0;
    req_valid[2] = 1'b1;
    exp_q.push_back({1'b0, 32'h00112233});
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ld_en[2] = 1'b1; ld_data[2] = 8'hAA;
    @(negedge clk);
    ld_en[2] = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (rsp_valid[2] !== 1'b1 || {rsp_err[2], rsp_data[2]} !== e) begin
      errors++;
      $display("FAIL load_capture_edge: valid=%b data=%h, want valid=1 data=%h",
               rsp_valid[2], rsp_data[2], e[31:0]);
    end
    @(negedge clk);
    exp_q.push_back({1'b0, 32'h00AA2233});
    fetch(2, 9'd0, data, err, lat, rl);
    e = exp_q.pop_front();
    checks++;
    if ({err, data} !== e) begin
      errors++;
      $display("FAIL load_after: data=%h, want %h", data, e[31:0]);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] data; logic err; int lat; logic rl; logic [32:0] e; int seen;
    req_addr[1] = 9'd4; req_valid[1] = 1'b1; rsp_ready[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst_n[1] = 1'b0;
    #1;
    checks++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait: valid=%b ready=%b, want 0 1", rsp_valid[1], req_ready[1]);
    end
    ld_en[1] = 1'b1; ld_addr[1] = 9'd8; ld_data[1] = 8'h5A;
    @(negedge clk);
    ld_en[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid[1] !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL reset_abandon: valid seen %0d cycles, ready=%b, want 0 cycles ready=1",
               seen, req_ready[1]);
    end
    exp_q.push_back({1'b0, 32'h77665544});
    exp_q.push_back({1'b0, 32'h33221100});
    fetch(1, 9'd4, data, err, lat, rl);
    e = exp_q.pop_front();
    checks++;
    if ({err, data} !== e || lat != 4) begin
      errors++;
      $display("FAIL refetch4: data=%h lat=%0d, want %h lat=4", data, lat, e[31:0]);
    end
    fetch(1, 9'd0, data, err, lat, rl);
    e = exp_q.pop_front();
    checks++;
    if ({err, data} !== e) begin
      errors++;
      $display("FAIL refetch0: data=%h, want %h", data, e[31:0]);
    end
    fetch(1, 9'd8, data, err, lat, rl);
    checks++;
    if (data[7:0] !== 8'h5A || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_load: byte0=%h err=%b, want 5a 0", data[7:0], err);
    end
    req_addr[0] = 9'd4; req_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_valid(0, lat);
    rst_n[0] = 1'b0;
    #1;
    checks++;
    if (lat != 1 || rsp_valid[0] !== 1'b0 || rsp_data[0] !== 32'h0 || req_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_resp: lat=%0d valid=%b data=%h ready=%b, want lat=1 0 00000000 1",
               lat, rsp_valid[0], rsp_data[0], req_ready[0]);
    end
    @(negedge clk);
    rst_n[0] = 1'b1;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_addr[d] = '0; rsp_ready[d] = 1'b1;
      ld_en[d] = 1'b0; ld_addr[d] = '0; ld_data[d] = '0;
    end
    @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      for (int d = 0; d < 3; d++) begin
        ld_en[d] = 1'b1; ld_addr[d] = 9'(b); ld_data[d] = 8'(b * 8'h11);
      end
      @(negedge clk);
    end
    for (int d = 0; d < 3; d++) ld_en[d] = 1'b0;
    test_reset();
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    @(negedge clk);
    test_aligned_be();
    test_latency_le();
    test_misaligned();
    test_backpressure();
    test_load_hazard();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_ctrl.md
Name: imem_ctrl

Overview:
Parametrised, byte-addressed instruction memory with a registered valid/ready fetch interface and configurable access latency, for the pipelined CPU's fetch stage. It is the successor to the combinational 512-byte ROM: it adds configurable depth, word width and endianness, multi-cycle access, backpressure, misalignment detection, and a byte load port. Storage stays a byte array named Mem, so benches can still preload it hierarchically from precharge text files.

Parameters:
ADDR_W, 9, byte address width; depth = 2**ADDR_W bytes
WORD_BYTES, 4, bytes per fetched word; must be a power of 2, 1..8
LATENCY, 0, extra wait cycles per access, 0..15
BIG_ENDIAN, 1, 1: byte at lowest address goes in the MS byte of rsp_data; 0: in the LS byte

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  fetch request present
req_ready  out  1  controller can accept a request
req_addr  in  ADDR_W  byte address of fetch
rsp_valid  out  1  response word valid
rsp_ready  in  1  consumer accepts response
rsp_data  out  8*WORD_BYTES  fetched word
rsp_err  out  1  misaligned request flag, valid with rsp_valid
ld_en  in  1  byte write enable
ld_addr  in  ADDR_W  byte write address
ld_data  in  8  byte write data

Behaviour:
- One clock. Reset is asynchronous and active-low: rst_n low forces state IDLE immediately, clears the wait counter to 0, and drives rsp_valid=0, rsp_err=0 and rsp_data=0. req_ready=1 once in IDLE. Mem contents are not cleared by reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE: req_ready=1.
  - On req_valid at a clock edge (accept edge k): latch req_addr, load cnt=LATENCY, go to WAIT.
- WAIT: req_ready=0.
  - If cnt != 0: decrement cnt.
  - If cnt == 0: capture the word, set rsp_valid, go to RESP.
  - rsp_valid therefore rises after edge k+1+LATENCY.
- RESP: rsp_valid=1, req_ready=0. rsp_data and rsp_err stay stable until handshake.
  - On rsp_ready at an edge: rsp_valid=0 and go to IDLE.
  - Back-to-back requests get one IDLE cycle between them; there is no same-cycle re-accept.
- Word capture:
  - Byte i of the word is Mem[addr+i], for i = 0..WORD_BYTES-1.
  - BIG_ENDIAN=1 places byte 0 at rsp_data[8*WORD_BYTES-1 -: 8]. BIG_ENDIAN=0 places it at [7:0].
  - Aligned addresses never cross the top of memory, so no wrap occurs.
- Misalignment: if addr[log2(WORD_BYTES)-1:0] != 0, the capture gives rsp_err=1 and rsp_data=0. No memory read is performed. Latency is unchanged. WORD_BYTES=1 never errors.
- Load port:
  - ld_en high at an edge writes ld_data to Mem[ld_addr] in any state, including during reset.
  - Writes before the capture edge are visible in the response.
  - A write on the capture edge itself is read-before-write: the response carries the old byte.
- Reset mid-operation (WAIT or RESP): the pending access is abandoned with no response. After release, the block is in IDLE with req_ready=1.
- req_addr, req_valid and rsp_ready are don't-care outside the states that sample them.

Test Plan:
- Preload Mem[0..7]=00,11,22,33,44,55,66,77; LATENCY=0, BIG_ENDIAN=1; request addr 0 with rsp_ready=1 -> rsp_valid one cycle after accept, rsp_data=32'h00112233, rsp_err=0; then addr 4 -> 32'h44556677.
- Same preload, BIG_ENDIAN=0, LATENCY=3; request addr 4 -> rsp_valid rises exactly 4 edges after accept, rsp_data=32'h77665544; req_ready=0 throughout.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data held constant, req_ready stays 0, a second req_valid is ignored; release -> IDLE, then the second request is accepted.
- Misaligned: request addr 9'h006 -> rsp_err=1, rsp_data=0; next aligned request addr 0 -> rsp_err=0.
- Load hazard, LATENCY=2: accept addr 0; ld_en writes Mem[1]=AA one edge after accept -> rsp_data=32'h00AA2233. Repeat with the write on the capture edge -> old value 32'h00112233.
- Assert rst_n low during WAIT -> rsp_valid=0 immediately, no response after release, req_ready=1, Mem[0..7] unchanged on refetch.
